// File: rtl/comma_aligner.sv
// Bit-serial comma aligner with hunt/verify/locked qualification; emits one 10-bit code group per 10 clocks once locked.
// Outputs registered, strobe one clock after each boundary; no backpressure, the consumer takes every strobe.
module comma_aligner #(
    parameter int WIDTH    = 10,
    parameter int LOCK_CNT = 3,
    parameter int MISS_MAX = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inputdata_i,
    input  logic             realign_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid_o,
    output logic             comma_o,
    output logic             locked_o
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(MISS_MAX + 1);
    localparam logic [GW-1:0] LOCK_CNT_W = GW'(LOCK_CNT);
    localparam logic [MW-1:0] MISS_MAX_W = MW'(MISS_MAX);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] shift_q;
    logic [3:0]      phase_q, phase_d;
    logic [GW-1:0]   good_q, good_d, good_inc;
    logic [MW-1:0]   miss_q, miss_d, miss_inc;
    logic            comma, bnd, strobe;

    assign comma    = (shift_q[WIDTH-1 -: 7] == 7'b0011111) |
                      (shift_q[WIDTH-1 -: 7] == 7'b1100000);
    assign bnd      = (phase_q == 4'd9);
    assign good_inc = good_q + GW'(1);
    assign miss_inc = miss_q + MW'(1);

    always_comb begin
        state_d = state_q;
        phase_d = bnd ? 4'd0 : phase_q + 4'd1;
        good_d  = good_q;
        miss_d  = miss_q;
        strobe  = 1'b0;
        if (realign_i) begin
            // Re-hunt request overrides any comma or boundary seen this cycle.
            state_d = HUNT;
            good_d  = '0;
            miss_d  = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (comma) begin
                        phase_d = 4'd0;
                        good_d  = GW'(1);
                        if (LOCK_CNT == 1) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (comma && bnd) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_CNT_W) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else if (comma) begin
                        state_d = HUNT;
                        good_d  = '0;
                    end
                end
                LOCKED: begin
                    strobe = bnd;
                    if (comma && bnd) begin
                        miss_d = '0;
                    end else if (comma) begin
                        miss_d = miss_inc;
                        if (miss_inc == MISS_MAX_W) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= HUNT;
            shift_q      <= '0;
            phase_q      <= 4'd0;
            good_q       <= '0;
            miss_q       <= '0;
            word_o       <= '0;
            word_valid_o <= 1'b0;
            comma_o      <= 1'b0;
            locked_o     <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= {shift_q[WIDTH-2:0], inputdata_i};
            phase_q      <= phase_d;
            good_q       <= good_d;
            miss_q       <= miss_d;
            word_valid_o <= strobe;
            locked_o     <= (state_d == LOCKED);
            if (strobe) begin
                word_o  <= shift_q;
                comma_o <= comma;
            end
        end
    end

endmodule

// File: tb/tb_comma_aligner.sv
// Randomized bench for comma_aligner against a bit-history / cycle-arithmetic reference model.
module tb_comma_aligner;

    localparam int LOCK_CNT = 3;
    localparam int MISS_MAX = 4;
    localparam logic [9:0] K_N  = 10'b0011111010;
    localparam logic [9:0] K_P  = 10'b1100000101;
    localparam logic [9:0] D215 = 10'b1010101010;

    logic       clk = 1'b0;
    logic       rst_n, din, realign;
    logic [9:0] word;
    logic       word_valid, comma, locked;

    always #5 clk = ~clk;

    comma_aligner #(.WIDTH(10), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .inputdata_i  (din),
        .realign_i    (realign),
        .word_o       (word),
        .word_valid_o (word_valid),
        .comma_o      (comma),
        .locked_o     (locked)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: received-bit history, alignment as cycle distance from the hunt comma.
    bit         hist[$];
    int         cyc = 0;
    int         mode = 0;     // 0 hunt, 1 verify, 2 locked
    int         anchor = 0;
    int         good = 0;
    int         miss = 0;
    logic [9:0] m_word = '0;
    bit         m_valid = 0, m_comma = 0, m_locked = 0;

    function automatic logic [9:0] window();
        logic [9:0] w;
        int idx;
        w = '0;
        for (int i = 0; i < 10; i++) begin
            idx = hist.size() - 1 - i;
            if (idx >= 0) w[i] = hist[idx];
        end
        return w;
    endfunction

    task automatic model_step(input bit d, input bit rl, input bit rs);
        logic [9:0] w;
        bit c, b;
        cyc++;
        m_valid = 0;
        if (!rs) begin
            hist.delete();
            mode = 0; good = 0; miss = 0;
            m_word = '0; m_comma = 0; m_locked = 0;
            return;
        end
        w = window();
        c = (w[9:3] == 7'b0011111) || (w[9:3] == 7'b1100000);
        b = (mode != 0) && (((cyc - anchor) % 10) == 0);
        if (rl) begin
            mode = 0; good = 0; miss = 0;
        end else if (mode == 0) begin
            if (c) begin
                anchor = cyc;
                good   = 1;
                miss   = 0;
                mode   = (LOCK_CNT == 1) ? 2 : 1;
            end
        end else if (mode == 1) begin
            if (c && b) begin
                good++;
                if (good == LOCK_CNT) begin mode = 2; miss = 0; end
            end else if (c) begin
                mode = 0; good = 0;
            end
        end else begin
            if (b) begin m_valid = 1; m_word = w; m_comma = c; end
            if (c && b) miss = 0;
            else if (c) begin
                miss++;
                if (miss == MISS_MAX) mode = 0;
            end
        end
        hist.push_back(d);
        if (hist.size() > 20) void'(hist.pop_front());
        m_locked = (mode == 2);
    endtask

    int         stepn = 0;
    int         lock_rise = -1, valid_rise = -1, d215_cnt = 0;
    bit         prev_locked = 0, saw_unlock = 0, rd = 0;
    logic [1:0] rl_obs = 2'b11;
    logic [12:0] rst_obs = '1;

    task automatic step(input bit d, input bit rl, input bit rs);
        din = d; realign = rl; rst_n = rs;
        @(posedge clk);
        model_step(d, rl, rs);
        #1;
        stepn++;
        check("locked", 32'(locked), 32'(m_locked));
        check("valid", 32'(word_valid), 32'(m_valid));
        check("word", 32'(word), 32'(m_word));
        check("comma", 32'(comma), 32'(m_comma));
        if (locked && lock_rise < 0) lock_rise = stepn;
        if (word_valid && valid_rise < 0) valid_rise = stepn;
        if (word_valid && !comma && word == D215) d215_cnt++;
        if (prev_locked && !locked) saw_unlock = 1;
        prev_locked = locked;
        if (rl) rl_obs = {locked, word_valid};
        if (!rs) rst_obs = {word, word_valid, comma, locked};
    endtask

    // kind 1 raises realign on bit cbit, kind 2 pulls reset on bit cbit.
    task automatic send_word(input logic [9:0] w, input int cbit, input int kind);
        for (int i = 0; i < 10; i++)
            step(w[9-i], (i == cbit) && (kind == 1), !((i == cbit) && (kind == 2)));
    endtask

    task automatic send_comma(input int cbit, input int kind);
        send_word(rd ? K_P : K_N, cbit, kind);
        rd = ~rd;
    endtask

    int n0;

    initial begin
        din = 0; realign = 0; rst_n = 0;
        repeat (3) step(0, 0, 0);
        repeat (50) step(0, 0, 1);
        check("idle_locked", 32'(locked), 32'd0);

        // Lock at a random phase and measure latencies from the first comma.
        repeat ($urandom_range(0, 9)) step(0, 0, 1);
        lock_rise = -1; valid_rise = -1;
        send_comma(-1, 0);
        n0 = stepn;
        repeat (5) send_comma(-1, 0);
        check("lock_latency", lock_rise - n0, 21);
        check("strobe_latency", valid_rise - n0, 31);

        // Data after lock.
        repeat (3) send_comma(-1, 0);
        d215_cnt = 0;
        repeat (5) send_word(D215, -1, 0);
        send_comma(-1, 0);
        check("d215_strobes", d215_cnt, 5);
        check("d215_locked", 32'(locked), 32'd1);

        // Bit slip, then re-hunt at the new phase.
        saw_unlock = 0;
        step(1'($urandom_range(0, 1)), 0, 1);
        repeat (10) send_comma(-1, 0);
        check("slip_unlock", 32'(saw_unlock), 32'd1);
        check("slip_relock", 32'(locked), 32'd1);

        // Realign on a boundary cycle: unlock next cycle, no strobe.
        rl_obs = 2'b11;
        send_comma(0, 1);
        check("realign_obs", 32'(rl_obs), 32'd0);
        repeat (6) send_comma(-1, 0);
        check("realign_relock", 32'(locked), 32'd1);

        // Reset five bits into a word while locked.
        rst_obs = '1;
        send_comma(5, 2);
        check("reset_outputs", 32'(rst_obs), 32'd0);
        valid_rise = -1;
        n0 = stepn;
        repeat (7) send_comma(-1, 0);
        check("reset_first_strobe", 32'(valid_rise - n0 >= 30), 32'd1);
        check("reset_relock", 32'(locked), 32'd1);

        // Random episodes.
        repeat (40) begin
            case ($urandom_range(0, 7))
                0, 1, 2: repeat ($urandom_range(1, 6)) send_comma(-1, 0);
                3:       send_word(10'($urandom_range(0, 1023)), -1, 0);
                4:       repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 0, 1);
                5:       send_word(D215, int'($urandom_range(0, 9)), 1);
                6:       send_comma(int'($urandom_range(0, 9)), 2);
                default: repeat ($urandom_range(1, 4)) send_word(D215, -1, 0);
            endcase
        end
        repeat (10) send_comma(-1, 0);
        check("final_lock", 32'(locked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
